// File: rtl/bank_rr_arbiter_if.sv
// Bank read-arbiter bus: per-CPU request/grant/return signals plus the bank read port.
// Handshake: a CPU holds req_cpu[i] and ra_cpu[i] stable until it sees gnt_cpu[i] (a
// single-cycle combinational pulse); it may withdraw req before the grant, and must drop
// req after the grant unless it issues another read. Read data arrives on the shared
// rdata_cpu bus qualified by the one-hot, single-cycle rvalid_cpu pulse.
// dbg_busy mirrors the arbiter FSM (1 = BUSY) for observation only.
interface bank_rr_arbiter_if #(
    parameter int NUM_CPU       = 3,
    parameter int SHIRINA_BANKI = 5,
    parameter int DATA_W        = 32
);
    logic [NUM_CPU-1:0]                    req_cpu;
    logic [NUM_CPU-1:0][SHIRINA_BANKI-1:0] ra_cpu;
    logic [NUM_CPU-1:0]                    gnt_cpu;
    logic [NUM_CPU-1:0]                    rvalid_cpu;
    logic [DATA_W-1:0]                     rdata_cpu;
    logic                                  bank_re;
    logic [SHIRINA_BANKI-1:0]              bank_ra;
    logic [DATA_W-1:0]                     bank_rdata;
    logic                                  dbg_busy;

    // Arbiter side
    modport slave (
        input  req_cpu, ra_cpu, bank_rdata,
        output gnt_cpu, rvalid_cpu, rdata_cpu, bank_re, bank_ra, dbg_busy
    );

    // CPU / bank-model side
    modport master (
        output req_cpu, ra_cpu, bank_rdata,
        input  gnt_cpu, rvalid_cpu, rdata_cpu, bank_re, bank_ra, dbg_busy
    );
endinterface

// File: rtl/bank_rr_arbiter.sv
// Per-bank round-robin read arbiter. One read in flight at a time: grant in IDLE,
// wait RD_LAT cycles in BUSY, then return data to the owner with a registered pulse.
// Optional feature macro: BANK_ARB_STATS_EN adds a saturating 16-bit stall_cnt output
// counting cycles in which some requesting CPU is left without a grant.
module bank_rr_arbiter #(
    parameter int NUM_CPU       = 3,
    parameter int SHIRINA_BANKI = 5,
    parameter int DATA_W        = 32,
    parameter int RD_LAT        = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bank_rr_arbiter_if.slave     bus
`ifdef BANK_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam int CPU_W = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q;
    logic [CPU_W-1:0]     prio_q;
    logic [CPU_W-1:0]     owner_q;
    logic [LAT_W-1:0]     lat_cnt_q;
    logic [NUM_CPU-1:0]   rvalid_q;
    logic [DATA_W-1:0]    rdata_q;

    logic                 win_found;
    logic [CPU_W-1:0]     win_idx;
    logic [NUM_CPU-1:0]   gnt_vec;
    logic                 re_vec;
    logic [SHIRINA_BANKI-1:0] ra_vec;
    logic [NUM_CPU-1:0]   owner_oh;

    // Round-robin winner: first pass takes requesters at or above prio, second pass wraps to the rest
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_CPU; i++) begin
            if (!win_found && bus.req_cpu[i] && (CPU_W'(i) >= prio_q)) begin
                win_found = 1'b1;
                win_idx   = CPU_W'(i);
            end
        end
        for (int i = 0; i < NUM_CPU; i++) begin
            if (!win_found && bus.req_cpu[i]) begin
                win_found = 1'b1;
                win_idx   = CPU_W'(i);
            end
        end
    end

    // Grant and bank read port are only driven in IDLE when a winner exists
    always_comb begin
        gnt_vec = '0;
        re_vec  = 1'b0;
        ra_vec  = '0;
        if (state_q == IDLE && win_found) begin
            gnt_vec[win_idx] = 1'b1;
            re_vec           = 1'b1;
            ra_vec           = bus.ra_cpu[win_idx];
        end
    end

    // One-hot decode of the current owner for the return pulse
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // Arbiter FSM with registered return data and valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= '0;
            owner_q   <= '0;
            lat_cnt_q <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        owner_q   <= win_idx;
                        prio_q    <= (win_idx == CPU_W'(NUM_CPU - 1)) ? '0 : win_idx + CPU_W'(1);
                        lat_cnt_q <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
                        rdata_q  <= bus.bank_rdata;
                        rvalid_q <= owner_oh;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BANK_ARB_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where any requester is left waiting; sticks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (((bus.req_cpu & ~gnt_vec) != '0) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign bus.gnt_cpu    = gnt_vec;
    assign bus.bank_re    = re_vec;
    assign bus.bank_ra    = ra_vec;
    assign bus.rvalid_cpu = rvalid_q;
    assign bus.rdata_cpu  = rdata_q;
    assign bus.dbg_busy   = (state_q == BUSY);
endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Bench for bank_rr_arbiter: a behavioural round-robin model (modulo search over the
// request vector, countdown for the in-flight read, expected-data queue) is stepped
// alongside the DUT; directed cases plus randomized CPU request traffic.
module tb_bank_rr_arbiter;
    localparam int NUM_CPU = 3;
    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int RD_LAT  = 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_rr_arbiter_if #(.NUM_CPU(NUM_CPU), .SHIRINA_BANKI(AW), .DATA_W(DW)) bus ();
`ifdef BANK_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    bank_rr_arbiter #(
        .NUM_CPU(NUM_CPU), .SHIRINA_BANKI(AW), .DATA_W(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef BANK_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // scoreboard / reference model state
    int chk_cnt = 0;
    int err_cnt = 0;
    int m_prio  = 0;
    int m_left  = 0;
    int m_owner = 0;
    logic [NUM_CPU-1:0] exp_gnt    = '0;
    logic [NUM_CPU-1:0] exp_rvalid = '0;
    logic [DW-1:0]      exp_rdata  = '0;
    logic [15:0]        exp_stall  = '0;
    logic [DW-1:0]      exp_q[$];
    logic [DW-1:0]      mem[32];
    logic [DW-1:0]      dpipe[RD_LAT];
    logic [NUM_CPU-1:0] pend = '0;
    logic [AW-1:0]      paddr[NUM_CPU];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven at the negedge; check, then advance model.
    task automatic step();
        int w;
        logic [AW-1:0] exp_ra;
        logic          obs_re;
        logic [AW-1:0] obs_ra;
        bus.bank_rdata = dpipe[RD_LAT-1];
        w       = -1;
        exp_gnt = '0;
        exp_ra  = '0;
        if (m_left == 0) begin
            for (int k = 0; k < NUM_CPU; k++) begin
                if (w < 0 && bus.req_cpu[(m_prio + k) % NUM_CPU]) w = (m_prio + k) % NUM_CPU;
            end
        end
        if (w >= 0) begin
            exp_gnt[w] = 1'b1;
            exp_ra     = bus.ra_cpu[w];
        end
        #1;
        check("gnt", 32'(bus.gnt_cpu), 32'(exp_gnt));
        check("bank_re", 32'(bus.bank_re), 32'(w >= 0));
        check("bank_ra", 32'(bus.bank_ra), 32'(exp_ra));
        check("rvalid", 32'(bus.rvalid_cpu), 32'(exp_rvalid));
        check("rdata", bus.rdata_cpu, exp_rdata);
        check("busy", 32'(bus.dbg_busy), 32'(m_left != 0));
`ifdef BANK_ARB_STATS_EN
        check("stall", 32'(stall_cnt), 32'(exp_stall));
`endif
        obs_re = bus.bank_re;
        obs_ra = bus.bank_ra;
        @(posedge clk);
        if (((bus.req_cpu & ~exp_gnt) != '0) && exp_stall != 16'hFFFF) exp_stall++;
        if (m_left == 0) begin
            exp_rvalid = '0;
            if (w >= 0) begin
                m_left  = RD_LAT;
                m_owner = w;
                m_prio  = (w + 1) % NUM_CPU;
                exp_q.push_back(mem[exp_ra]);
            end
        end else begin
            m_left--;
            exp_rvalid = '0;
            if (m_left == 0) begin
                exp_rvalid[m_owner] = 1'b1;
                if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
            end
        end
        // bank model: data for an accepted read appears RD_LAT cycles later, junk otherwise
        for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
        dpipe[0] = obs_re ? mem[obs_ra] : $urandom;
        @(negedge clk);
    endtask

    // Called at a negedge; holds reset for one cycle with no requests.
    task automatic do_reset();
        rst         = 1'b1;
        bus.req_cpu = '0;
        #1;
        check("rst_gnt", 32'(bus.gnt_cpu), 32'h0);
        check("rst_re", 32'(bus.bank_re), 32'h0);
        check("rst_rvalid", 32'(bus.rvalid_cpu), 32'h0);
        check("rst_rdata", bus.rdata_cpu, 32'h0);
`ifdef BANK_ARB_STATS_EN
        check("rst_stall", 32'(stall_cnt), 32'h0);
`endif
        @(negedge clk);
        rst        = 1'b0;
        m_prio     = 0;
        m_left     = 0;
        exp_rvalid = '0;
        exp_rdata  = '0;
        exp_stall  = '0;
        exp_q.delete();
    endtask

    initial begin
        bus.req_cpu    = '0;
        bus.ra_cpu     = '0;
        bus.bank_rdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[5'h0A] = 32'hDEAD_BEEF;
        for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
        for (int i = 0; i < NUM_CPU; i++) paddr[i] = '0;
        @(negedge clk);
        do_reset();

        // idle after reset
        for (int n = 0; n < 10; n++) step();

        // single read from CPU0 at address 0A
        bus.req_cpu   = 3'b001;
        bus.ra_cpu[0] = 5'h0A;
        #1;
        check("dir_gnt", 32'(bus.gnt_cpu), 32'h1);
        check("dir_ra", 32'(bus.bank_ra), 32'h0A);
        step();
        bus.req_cpu = '0;
        step();
        #1;
        check("dir_rvalid", 32'(bus.rvalid_cpu), 32'h1);
        check("dir_rdata", bus.rdata_cpu, 32'hDEAD_BEEF);
        step();
        step();

        // all three requesting continuously from reset: grants 0,1,2,0,... every 2 cycles
        do_reset();
        bus.req_cpu = 3'b111;
        for (int c = 0; c < NUM_CPU; c++) bus.ra_cpu[c] = AW'($urandom_range(0, 31));
        for (int g = 0; g < 8; g++) begin
            #1;
            check("rr_order", 32'(bus.gnt_cpu), 32'(1 << (g % 3)));
            step();
            step();
`ifdef BANK_ARB_STATS_EN
            if (g == 2) begin
                #1;
                check("stall_six", 32'(stall_cnt), 32'd6);
            end
`endif
        end
        bus.req_cpu = '0;
        for (int n = 0; n < 3; n++) step();

        // grant CPU1 so prio=2, then 011 wraps to CPU0 before CPU1
        bus.req_cpu   = 3'b010;
        bus.ra_cpu[1] = AW'($urandom_range(0, 31));
        step();
        bus.req_cpu = '0;
        step();
        step();
        bus.req_cpu = 3'b011;
        #1;
        check("wrap_first", 32'(bus.gnt_cpu), 32'h1);
        step();
        step();
        #1;
        check("wrap_second", 32'(bus.gnt_cpu), 32'h2);
        step();
        bus.req_cpu = '0;
        for (int n = 0; n < 3; n++) step();

        // reset the cycle after a grant: access dropped, prio back to 0
        bus.req_cpu = 3'b010;
        step();
        bus.req_cpu = '0;
        do_reset();
        bus.req_cpu = 3'b010;
        #1;
        check("post_rst_gnt", 32'(bus.gnt_cpu), 32'h2);
        step();
        bus.req_cpu = '0;
        for (int n = 0; n < 3; n++) step();
        do_reset();
        bus.req_cpu = 3'b110;
        #1;
        check("post_rst_prio", 32'(bus.gnt_cpu), 32'h2);
        step();
        bus.req_cpu = '0;
        for (int n = 0; n < 3; n++) step();

        // randomized CPU traffic with hold-until-grant and occasional withdrawal
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NUM_CPU; c++) begin
                if (!pend[c]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[c]  = 1'b1;
                        paddr[c] = AW'($urandom_range(0, 31));
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    pend[c] = 1'b0;
                end
            end
            bus.req_cpu = pend;
            for (int c = 0; c < NUM_CPU; c++) bus.ra_cpu[c] = paddr[c];
            step();
            pend = pend & ~exp_gnt;
        end
        bus.req_cpu = '0;
        for (int n = 0; n < 4; n++) step();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
